dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that serves the load/store requests the pipeline CPU issues from its MEM stage. It accepts one request at a time over a valid/ready request channel, holds it for a configurable number of wait states, and performs a byte-enabled word write or a word read. It then returns a response over a valid/ready response channel. It replaces the single-cycle combinational data memory so that memory latency and back-pressure become visible to the pipeline.

## Interface
- `ADDR_W`, default 10: word-address bits; depth = 2**ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between acceptance and access; legal range 0..15.

Ports, with clock and reset first:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i covers `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected (see Configuration).
- `busy`  out  1  state ≠ IDLE.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - Acceptance occurs on the edge where `req_valid`&&`req_ready`. At that edge, `write`/`addr`/`wdata`/`be` are captured.
  - If `WAIT_CYCLES`=0, the access is performed and the FSM goes to RESP.
  - Otherwise the FSM goes to WAIT with counter = `WAIT_CYCLES`−1.
- **WAIT:**
  - `req_ready`=0.
  - The counter decrements each edge.
  - On the edge where counter==0, the access is performed and the FSM goes to RESP.
- **Access:**
  - Word index = `addr[ADDR_W+1:2]`.
  - A store writes only the enabled bytes. `be`=4'b0000 leaves memory unchanged but still produces a response. The store response has `rsp_rdata`=0.
  - A load registers the full word into `rsp_rdata`; `be` is ignored.
- **RESP:**
  - `rsp_valid`=1. `rsp_rdata`/`rsp_err` are held stable until the handshake.
  - On the edge where `rsp_valid`&&`rsp_ready`, the FSM goes to IDLE and `rsp_valid`, `rsp_rdata` and `rsp_err` clear to 0.
- **Input behaviour:** Request inputs are ignored outside IDLE. There is no same-cycle response-to-accept overlap.
- **Memory array:** not cleared by reset; contents are undefined until written.
- **Reset mid-operation:** the transaction is aborted.
  - A store still in WAIT is never committed.
  - A store already committed (FSM in RESP) stays in memory; its response is dropped.

## Timing
- **Reset values:** `req_ready`=1 while `rst` is low after release, and 0 while `rst` is asserted. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, FSM=IDLE, counter=0.
- **Response latency:** `rsp_valid` rises on the `WAIT_CYCLES`-th rising edge after the accepting edge. With `WAIT_CYCLES`=0, it is high in the cycle directly after acceptance.
- **Write visibility:** a write is visible to any later accepted load.
- **Recovery:** `req_ready` returns high in the cycle after the response handshake edge.
- **Throughput:** the minimum request spacing is `WAIT_CYCLES`+2 cycles when `rsp_ready` is tied high.
- **Outputs:** all outputs are registered or decoded from FSM state only; there is no combinational path from `req_*` or `rsp_ready` to any output.

## Configuration
- **Macro:** `DMEM_RESP_ALIGN_CHECK_EN`.
- **Defined:** at acceptance, a request is flagged as an error if `addr[1:0]`≠0 or any of `addr[31:ADDR_W+2]`≠0.
  - Flagged requests follow the same FSM timing.
  - No memory write occurs.
  - The response carries `rsp_err`=1 and `rsp_rdata`=0.
- **Undefined:**
  - `addr[1:0]` and the upper address bits are ignored, so addresses wrap modulo depth.
  - `rsp_err` is constant 0.

## Test plan
- **Reset:** assert `rst` mid-cycle, asynchronously → `rsp_valid`=0, `busy`=0 immediately. After release, `req_ready`=1.
- **Store then load**, `WAIT_CYCLES`=2:
  - Store addr 0x10, data 0xDEADBEEF, be 4'hF → `rsp_valid` on the 2nd edge after acceptance, `rsp_rdata`=0.
  - Load 0x10 → `rsp_rdata`=0xDEADBEEF.
- **Byte enables:** over word 0x11223344 at addr 0x20, store data 0xAABBCCDD with be 4'b0101 → a load of 0x20 returns 0x11BB33DD. A following store with be 0 leaves it unchanged.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles on a load → `rsp_valid` and `rsp_rdata` are stable, `req_ready`=0, and a new `req_valid` is ignored. Raising `rsp_ready` gives `req_ready`=1 the next cycle.
- **Reset during WAIT:** reset during WAIT of a store of 0x55 to 0x40 → a subsequent load of 0x40 returns the prior value, not 0x55.
- **`WAIT_CYCLES`=0 and alignment check:**
  - A load is answered the cycle after acceptance.
  - With `DMEM_RESP_ALIGN_CHECK_EN`, a store to 0x13 → `rsp_err`=1 and memory is unchanged.
  - Without the macro, a store to 0x13 writes word 4.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Takes one request at a time, waits WAIT_CYCLES, performs a byte-enabled
// store or a word load, and then holds the response until it is taken.
// Optional feature: define DMEM_RESP_ALIGN_CHECK_EN to reject misaligned or
// out-of-range byte addresses. Without it, addresses wrap modulo the depth.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               write_q;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [DEPTH];

  logic               accept, access;
  logic               a_write;
  logic [31:0]        a_addr, a_wdata;
  logic [3:0]         a_be;
  logic [ADDR_W-1:0]  a_idx;
  logic               a_err;

  // Ready is a pure state decode, forced low while reset is held.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flags the accept edge and the access edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access operands: live request inputs when the access happens on the
  // accept edge (zero wait states), otherwise the captured request.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_write = req_write;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
    end else begin
      a_write = write_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_be    = be_q;
    end
    a_idx = a_addr[ADDR_W+1:2];
  end

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  // Reject misaligned addresses and any address beyond the array.
  always_comb begin
    a_err = (a_addr[1:0] != 2'b00) || ((a_addr >> (ADDR_W + 2)) != 32'd0);
  end
`else
  logic unused_addr_bits;
  // Low and high address bits are don't-care when checking is off.
  always_comb begin
    a_err            = 1'b0;
    unused_addr_bits = ^{a_addr[31:ADDR_W+2], a_addr[1:0]};
  end
`endif

  // Request capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Byte-enabled store into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (access && a_write && !a_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // Response payload: loaded on access, held through back-pressure,
  // cleared on the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      rdata_q <= (a_write || a_err) ? '0 : mem[a_idx];
      err_q   <= a_err;
    end else if (state_q == S_RESP && rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states,
// one with zero, both compared every cycle against a transaction-level model.
module tb_dmem_responder;

  localparam int unsigned AW = 5;
  localparam int unsigned NW = 1 << AW;
  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  int checks = 0;
  int passes = 0;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? int'(W0) : int'(W1);
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s[dut%0d]: got %h expected %h", nm, k, act, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] rm      [2][NW];
  bit          m_out   [2];
  int          m_since [2];
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wd    [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_rdata [2];
  bit          m_err   [2];

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    return (a % 4 != 0) || (a >= 4 * NW);
`else
    return (a != a);
`endif
  endfunction

  task automatic commit(input int k);
    int unsigned w;
    w = (m_addr[k] / 4) % NW;
    m_err[k]   = bad_addr(m_addr[k]);
    m_rdata[k] = 32'd0;
    if (!m_err[k]) begin
      if (m_wr[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be[k][b]) rm[k][w][8*b +: 8] = m_wd[k][8*b +: 8];
        end
      end else begin
        m_rdata[k] = rm[k][w];
      end
    end
  endtask

  // Model advances on each edge: edges since acceptance decide when the
  // response appears; a reset drops whatever is outstanding.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_out[k] = 1'b0;
      end else if (m_out[k]) begin
        if (m_since[k] >= wc(k)) begin
          if (rsp_ready[k]) m_out[k] = 1'b0;
        end else begin
          m_since[k]++;
          if (m_since[k] == wc(k)) commit(k);
        end
      end else if (req_valid[k]) begin
        m_wr[k]    = req_write[k];
        m_addr[k]  = req_addr[k];
        m_wd[k]    = req_wdata[k];
        m_be[k]    = req_be[k];
        m_out[k]   = 1'b1;
        m_since[k] = 0;
        if (wc(k) == 0) commit(k);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit vld;
    for (int k = 0; k < 2; k++) begin
      vld = m_out[k] && (m_since[k] >= wc(k));
      check("req_ready", k, 32'(req_ready[k]), 32'(!m_out[k] && !rst));
      check("busy",      k, 32'(busy[k]),      32'(m_out[k]));
      check("rsp_valid", k, 32'(rsp_valid[k]), 32'(vld));
      check("rsp_rdata", k, rsp_rdata[k],      vld ? m_rdata[k] : 32'd0);
      check("rsp_err",   k, 32'(rsp_err[k]),   32'(vld && m_err[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int g;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    g = 0;
    while (!req_ready[k] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("accept_timeout", k, 32'(g >= 50), 32'd0);
    @(negedge clk);
    // junk request held while busy must be ignored
    req_valid[k] = 1'b1;
    req_write[k] = 1'($urandom);
    req_addr[k]  = $urandom_range(0, 4 * NW - 1);
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
    lat = 0;
    while (!rsp_valid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_timeout", k, 32'(lat >= 50), 32'd0);
    repeat (hold) @(negedge clk);
    rsp_ready[k] = 1'b1;
    rd = rsp_rdata[k];
    er = rsp_err[k];
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b0;
  endtask

  // Accept a store, let `edges` more edges pass, then reset asynchronously.
  task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] d, input int edges);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_write[k] = 1'b1;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = 4'hF;
    @(posedge clk);
    repeat (edges) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy",      k, 32'(busy[k]),      32'd0);
    check("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
    check("rst_req_ready", k, 32'(req_ready[k]), 32'd0);
    @(negedge clk);
    #1;
    req_valid[k] = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          k;
    logic [31:0] a;

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_be[i]    = '0;
      rsp_ready[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("post_rst_ready", 0, 32'(req_ready[0]), 32'd1);
    check("post_rst_ready", 1, 32'(req_ready[1]), 32'd1);

    // Preload every word so later loads have defined contents.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < int'(NW); w++) begin
        txn(i, 1'b1, 32'(4 * w), $urandom, 4'hF, 0, rd, er, lat);
      end
    end

    // Store then load, two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("store_latency", 0, 32'(lat), 32'd2);
    check("store_rdata",   0, rd,       32'd0);
    check("store_err",     0, 32'(er),  32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("load_rdata",    0, rd,       32'hDEADBEEF);

    // Byte enables.
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1, rd, er, lat);
    check("be_merge",      0, rd,       32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
    check("be_zero",       0, rd,       32'h11BB33DD);

    // Back-pressure for five cycles on a load.
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    check("bp_rdata",      0, rd,       32'hDEADBEEF);

    // Reset during WAIT drops the store; reset in RESP keeps it.
    txn(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, rd, er, lat);
    abort_store(0, 32'h40, 32'h55, 1);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    check("abort_wait",    0, rd,       32'h12345678);
    abort_store(0, 32'h44, 32'h66, 2);
    txn(0, 1'b0, 32'h44, 32'h0, 4'h0, 0, rd, er, lat);
    check("abort_resp",    0, rd,       32'h66);

    // Zero wait states and the alignment rule.
    txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("w0_latency",    1, 32'(lat), 32'd0);
    check("w0_rdata",      1, rd,       32'hCAFEF00D);
    txn(1, 1'b1, 32'h13, 32'h0BADBEEF, 4'hF, 0, rd, er, lat);
    check("unaligned_rd",  1, rd,       32'd0);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    check("unaligned_err", 1, 32'(er),  32'd1);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("unaligned_mem", 1, rd,       32'hCAFEF00D);
`else
    check("unaligned_err", 1, 32'(er),  32'd0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("unaligned_mem", 1, rd,       32'h0BADBEEF);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = $urandom_range(0, 4 * NW - 1);
      txn(k, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd, er, lat);
      check("rand_latency", k, 32'(lat), 32'(wc(k)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
